l1_bus_arbiter: RTL and testbench
=================================

Name: l1_bus_arbiter

Overview:
- Shares the single per-hart L2 line port between the L1 instruction cache refill path and the L1 data cache refill/writeback path.
- Grants one requester at a time with round-robin fairness and latches the address and write data at grant.
- Drives the L2 request until L2 signals data valid, then routes the response back to the granted requester.
- Sits between imem/dmem and the L2 inside each hart.

Parameters:
- BLK_LEN, 59: line (block) address width in bits (64 - log2 of line bytes).
- LINE, 256: cache line width in bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- i_addr  in  BLK_LEN  imem refill line address.
- i_rd  in  1  imem refill request, level; held until i_dv.
- i_data  out  LINE  refill data to imem.
- i_dv  out  1  one-cycle pulse: i_data valid, request complete.
- d_addr  in  BLK_LEN  dmem line address.
- d_rd  in  1  dmem refill request, level.
- d_wr  in  1  dmem writeback request, level.
- d_wdata  in  LINE  writeback line.
- d_data  out  LINE  refill data to dmem.
- d_dv  out  1  one-cycle pulse: read data valid or write accepted.
- l2_addr  out  BLK_LEN  L2 line address.
- l2_rd  out  1  L2 read request, held until l2_dv.
- l2_wr  out  1  L2 write request, held until l2_dv.
- l2_wdata  out  LINE  L2 write data.
- l2_data  in  LINE  L2 read data, valid only in the l2_dv cycle.
- l2_dv  in  1  L2 completion pulse.
- busy  out  1  arbiter not in IDLE.

Behaviour:
- Reset: rst_n is synchronous and active-low; clock is clk. On reset:
  - state = IDLE.
  - l2_rd, l2_wr, l2_addr, l2_wdata, i_dv, d_dv, busy = 0.
  - last_gnt = D, so imem wins the first tie.
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE:
  - req_i = i_rd; req_d = d_rd | d_wr.
  - Only one requesting: grant it.
  - Both requesting: grant the one not equal to last_gnt.
  - On grant at edge N:
    - l2_addr is loaded from the winner's address.
    - l2_rd or l2_wr is set; they are registered, so they are high from cycle N+1.
    - l2_wdata is loaded from d_wdata for a write.
    - last_gnt is updated.
    - Next state is BUSY_I or BUSY_D.
  - d_rd & d_wr together is illegal. The write wins and the read is ignored for that grant.
- BUSY_x:
  - l2_addr, l2_rd/l2_wr and l2_wdata stay stable. Requester inputs are not re-sampled.
  - On l2_dv (same cycle, combinational):
    - i_dv = l2_dv & BUSY_I & i_rd.
    - d_dv = l2_dv & BUSY_D & (d_rd | d_wr).
    - At the l2_dv edge, l2_rd and l2_wr clear and state goes to DONE.
- Data routing: i_data = d_data = l2_data at all times (broadcast). Consumers qualify with their dv.
- DONE: exactly one cycle, no grant, then IDLE. This bubble lets the completed requester drop its request, so it is never re-granted on a stale level.
  - Minimum back-to-back spacing: l2_dv to the next l2_rd/l2_wr is 3 cycles.
- Abandon: if the requester deasserts mid-transaction (e.g. flush), the L2 transaction still completes. Its dv is suppressed and the arbiter proceeds via DONE.
- Reset mid-transaction: abort immediately. The L2 is reset in the same domain, so no completion is awaited.
- Fairness: with both requesting continuously, grants alternate I, D, I, D. A requester waits at most one foreign transaction plus the DONE bubble.
- busy = (state != IDLE).

Decomposition:
- config.v: state encodings (2-bit `ARB_S_*`) and line/block width macros shared with the imem/dmem caches.
- Sub-module rr_arb2: a combinational 2-way round-robin pick (req_i, req_d, last_gnt -> gnt_i, gnt_d).
- The FSM, latches and dv gating stay in l1_bus_arbiter.

Test Plan:
- Single imem read: i_rd=1, i_addr=0x123, L2 returns l2_dv 4 cycles later with data 0xA5.. -> l2_rd high from cycle 1 with l2_addr=0x123; i_dv=1 for exactly one cycle with i_data=0xA5..; d_dv stays 0.
- Simultaneous i_rd and d_rd held from reset -> imem is granted first; after its l2_dv plus DONE, dmem is granted; grants alternate over 6 transactions.
- dmem writeback: d_wr=1, d_wdata=0xDEAD.., d_addr=0x7F -> l2_wr=1 with matching data/address, stable until l2_dv; d_dv pulses once; l2_rd stays 0.
- Abandon: i_rd dropped 2 cycles after grant -> l2_rd held until l2_dv, i_dv stays 0, state returns to IDLE via DONE.
- Reset mid-BUSY_D: rst_n=0 for one cycle -> next cycle l2_rd=l2_wr=0, busy=0; a later request is served normally.
- Illegal d_rd & d_wr -> a write is issued (l2_wr=1, l2_rd=0).

Source files
------------

// File: rtl/l1_bus_arbiter_pkg.sv
// Shared types and defaults for the per-hart L1 -> L2 line port arbiter.
// State and grant encodings are reused by the imem/dmem refill logic.
package l1_bus_arbiter_pkg;

  localparam int DEF_BLK_LEN = 59;
  localparam int DEF_LINE    = 256;

  typedef enum logic [1:0] {
    ARB_S_IDLE   = 2'd0,
    ARB_S_BUSY_I = 2'd1,
    ARB_S_BUSY_D = 2'd2,
    ARB_S_DONE   = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

endpackage

// File: rtl/l1_bus_arbiter_rr_arb2.sv
// Two-way round-robin pick between the imem and dmem requesters.
// last_gnt = 1 means dmem won the previous grant, so imem wins a tie.
module l1_bus_arbiter_rr_arb2
  import l1_bus_arbiter_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_gnt,
  output logic gnt_i,
  output logic gnt_d
);

  // Single winner: the lone requester, or the one not served last on a tie.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (req_i && req_d) begin
      if (last_gnt == 1'(GNT_D)) begin
        gnt_i = 1'b1;
      end else begin
        gnt_d = 1'b1;
      end
    end else if (req_i) begin
      gnt_i = 1'b1;
    end else if (req_d) begin
      gnt_d = 1'b1;
    end else begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
    end
  end

endmodule

// File: rtl/l1_bus_arbiter.sv
// Shares the per-hart L2 line port between the imem refill path and the
// dmem refill/writeback path, one transaction at a time, round-robin.
module l1_bus_arbiter
  import l1_bus_arbiter_pkg::*;
#(
  parameter int BLK_LEN = DEF_BLK_LEN,
  parameter int LINE    = DEF_LINE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BLK_LEN-1:0] i_addr,
  input  logic               i_rd,
  output logic [LINE-1:0]    i_data,
  output logic               i_dv,
  input  logic [BLK_LEN-1:0] d_addr,
  input  logic               d_rd,
  input  logic               d_wr,
  input  logic [LINE-1:0]    d_wdata,
  output logic [LINE-1:0]    d_data,
  output logic               d_dv,
  output logic [BLK_LEN-1:0] l2_addr,
  output logic               l2_rd,
  output logic               l2_wr,
  output logic [LINE-1:0]    l2_wdata,
  input  logic [LINE-1:0]    l2_data,
  input  logic               l2_dv,
  output logic               busy
);

  arb_state_e state_r;
  gnt_e       last_gnt_r;
  logic       req_i_s;
  logic       req_d_s;
  logic       gnt_i_s;
  logic       gnt_d_s;
  logic       last_d_s;

  assign req_i_s  = i_rd;
  assign req_d_s  = d_rd | d_wr;
  assign last_d_s = (last_gnt_r == GNT_D);

  l1_bus_arbiter_rr_arb2 u_rr_arb2 (
    .req_i    (req_i_s),
    .req_d    (req_d_s),
    .last_gnt (last_d_s),
    .gnt_i    (gnt_i_s),
    .gnt_d    (gnt_d_s)
  );

  // Arbiter FSM with the latched L2 request fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ARB_S_IDLE;
      last_gnt_r <= GNT_D;
      l2_addr    <= {BLK_LEN{1'b0}};
      l2_wdata   <= {LINE{1'b0}};
      l2_rd      <= 1'b0;
      l2_wr      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state_r)
        ARB_S_IDLE: begin
          if (gnt_i_s) begin
            l2_addr    <= i_addr;
            l2_rd      <= 1'b1;
            last_gnt_r <= GNT_I;
            state_r    <= ARB_S_BUSY_I;
            busy       <= 1'b1;
          end else if (gnt_d_s) begin
            l2_addr    <= d_addr;
            last_gnt_r <= GNT_D;
            state_r    <= ARB_S_BUSY_D;
            busy       <= 1'b1;
            // A simultaneous read+write is illegal; the writeback takes priority.
            if (d_wr) begin
              l2_wr    <= 1'b1;
              l2_wdata <= d_wdata;
            end else begin
              l2_rd    <= 1'b1;
            end
          end else begin
            state_r <= ARB_S_IDLE;
          end
        end
        ARB_S_BUSY_I, ARB_S_BUSY_D: begin
          if (l2_dv) begin
            l2_rd   <= 1'b0;
            l2_wr   <= 1'b0;
            state_r <= ARB_S_DONE;
          end else begin
            state_r <= state_r;
          end
        end
        ARB_S_DONE: begin
          state_r <= ARB_S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= ARB_S_IDLE;
          l2_rd   <= 1'b0;
          l2_wr   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Completion is suppressed when the requester has abandoned its request.
  assign i_dv   = l2_dv & (state_r == ARB_S_BUSY_I) & i_rd;
  assign d_dv   = l2_dv & (state_r == ARB_S_BUSY_D) & (d_rd | d_wr);
  assign i_data = l2_data;
  assign d_data = l2_data;

endmodule

// File: tb/tb_l1_bus_arbiter.sv
// Randomized bench for l1_bus_arbiter: two random requesters and a random
// latency L2, checked against a transaction-level model of the arbiter.
module tb_l1_bus_arbiter;

  localparam int BL = 59;
  localparam int LN = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [BL-1:0] i_addr, d_addr, l2_addr;
  logic          i_rd, i_dv, d_rd, d_wr, d_dv, l2_rd, l2_wr, l2_dv, busy;
  logic [LN-1:0] i_data, d_data, d_wdata, l2_wdata, l2_data;

  int n_checks = 0;
  int n_errors = 0;

  // model state: owner 0 = none, 1 = imem, 2 = dmem
  int            c = 0;
  int            owner = 0;
  int            last_w = 2;
  int            ready_c = 0;
  int            lat = 0;
  logic [BL-1:0] t_addr;
  bit            t_wr;
  logic [LN-1:0] t_wdata;
  bit            i_done_prev = 1'b0;
  bit            d_done_prev = 1'b0;
  int            n_grant_i = 0;
  int            n_grant_d = 0;

  l1_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr), .i_rd(i_rd), .i_data(i_data), .i_dv(i_dv),
    .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr), .d_wdata(d_wdata),
    .d_data(d_data), .d_dv(d_dv),
    .l2_addr(l2_addr), .l2_rd(l2_rd), .l2_wr(l2_wr), .l2_wdata(l2_wdata),
    .l2_data(l2_data), .l2_dv(l2_dv), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [LN-1:0] act, input logic [LN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, c, act, exp);
    end
  endtask

  function automatic logic [LN-1:0] rand_line();
    logic [LN-1:0] r;
    for (int k = 0; k < LN / 32; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [BL-1:0] rand_blk();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[BL-1:0];
  endfunction

  // One clock of bench activity, entered and left at a negedge.
  task automatic run_cycle();
    bit exp_i_dv, exp_d_dv, req_i, req_d;
    int w;
    // registered outputs against the model
    if (owner != 0) begin
      check_eq("busy_xfer", 256'(busy), 256'(1'b1));
      check_eq("l2_addr", 256'(l2_addr), 256'(t_addr));
      check_eq("l2_rd", 256'(l2_rd), 256'(!t_wr));
      check_eq("l2_wr", 256'(l2_wr), 256'(t_wr));
      if (t_wr) check_eq("l2_wdata", l2_wdata, t_wdata);
    end else begin
      check_eq("busy_idle", 256'(busy), 256'(c < ready_c));
      check_eq("l2_rd_idle", 256'(l2_rd), 256'(1'b0));
      check_eq("l2_wr_idle", 256'(l2_wr), 256'(1'b0));
    end
    // imem requester: drop after completion, sometimes abandon, sometimes start
    if (i_done_prev) i_rd = 1'b0;
    else if (i_rd && $urandom_range(0, 19) == 0) i_rd = 1'b0;
    else if (!i_rd && $urandom_range(0, 2) == 0) begin
      i_rd = 1'b1;
      i_addr = rand_blk();
    end
    // dmem requester: reads, writebacks and the occasional illegal rd+wr
    if (d_done_prev || ((d_rd || d_wr) && $urandom_range(0, 19) == 0)) begin
      d_rd = 1'b0;
      d_wr = 1'b0;
    end else if (!(d_rd || d_wr) && $urandom_range(0, 2) == 0) begin
      w = $urandom_range(0, 9);
      d_rd = (w < 5) || (w == 9);
      d_wr = (w >= 5);
      d_addr = rand_blk();
      d_wdata = rand_line();
    end
    // L2: random latency, random data every cycle
    l2_data = rand_line();
    l2_dv = 1'b0;
    if (owner != 0) begin
      if (lat == 0) l2_dv = 1'b1;
      else lat--;
    end
    #1;
    exp_i_dv = l2_dv && owner == 1 && i_rd;
    exp_d_dv = l2_dv && owner == 2 && (d_rd || d_wr);
    check_eq("i_dv", 256'(i_dv), 256'(exp_i_dv));
    check_eq("d_dv", 256'(d_dv), 256'(exp_d_dv));
    check_eq("i_data", i_data, l2_data);
    check_eq("d_data", d_data, l2_data);
    i_done_prev = exp_i_dv;
    d_done_prev = exp_d_dv;
    // model: completion frees the port after a one-cycle bubble
    if (l2_dv) begin
      owner = 0;
      ready_c = c + 2;
    end else if (owner == 0 && c >= ready_c) begin
      req_i = i_rd;
      req_d = d_rd || d_wr;
      w = 0;
      if (req_i && req_d) w = (last_w == 2) ? 1 : 2;
      else if (req_i) w = 1;
      else if (req_d) w = 2;
      if (w != 0) begin
        owner = w;
        last_w = w;
        lat = $urandom_range(0, 4);
        if (w == 1) begin
          n_grant_i++;
          t_addr = i_addr;
          t_wr = 1'b0;
        end else begin
          n_grant_d++;
          t_addr = d_addr;
          t_wr = d_wr;
          t_wdata = d_wdata;
        end
      end
    end
    @(negedge clk);
    c++;
  endtask

  task automatic reset_model();
    owner = 0;
    last_w = 2;
    ready_c = c;
    lat = 0;
    i_done_prev = 1'b0;
    d_done_prev = 1'b0;
  endtask

  // Pull rst_n for one cycle while a dmem transaction is in flight.
  task automatic reset_mid_busy_d();
    int n = 0;
    while (owner != 2 && n < 500) begin
      run_cycle();
      n++;
    end
    check_eq("found_busy_d", 256'(owner), 256'(2));
    check_eq("pre_rst_busy", 256'(busy), 256'(1'b1));
    rst_n = 1'b0;
    l2_dv = 1'b0;
    @(negedge clk);
    c++;
    check_eq("rst_busy", 256'(busy), 256'(1'b0));
    check_eq("rst_l2_rd", 256'(l2_rd), 256'(1'b0));
    check_eq("rst_l2_wr", 256'(l2_wr), 256'(1'b0));
    check_eq("rst_l2_addr", 256'(l2_addr), 256'(0));
    rst_n = 1'b1;
    reset_model();
  endtask

  initial begin
    rst_n = 1'b0;
    i_rd = 1'b0; i_addr = '0;
    d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
    l2_dv = 1'b0; l2_data = '0;
    @(negedge clk);
    @(negedge clk);
    check_eq("reset_busy", 256'(busy), 256'(1'b0));
    check_eq("reset_l2_rd", 256'(l2_rd), 256'(1'b0));
    check_eq("reset_l2_wr", 256'(l2_wr), 256'(1'b0));
    check_eq("reset_l2_addr", 256'(l2_addr), 256'(0));
    check_eq("reset_l2_wdata", l2_wdata, 256'(0));
    check_eq("reset_i_dv", 256'(i_dv), 256'(1'b0));
    check_eq("reset_d_dv", 256'(d_dv), 256'(1'b0));
    rst_n = 1'b1;
    c = 0;
    reset_model();
    // both requesting from reset: imem must win the first tie
    i_rd = 1'b1; i_addr = 59'h123;
    d_rd = 1'b1; d_addr = 59'h7f;
    for (int k = 0; k < 3000; k++) run_cycle();
    reset_mid_busy_d();
    for (int k = 0; k < 3000; k++) run_cycle();
    check_eq("grants_i_seen", 256'(n_grant_i > 50), 256'(1'b1));
    check_eq("grants_d_seen", 256'(n_grant_d > 50), 256'(1'b1));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
